// File: rtl/latch_ctrl_pkg.sv
// Shared definitions for the latch write arbiter: FSM states, default sizing
// constants and the one-hot encoder used to drive latch enables.
package latch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_DW      = 8;
  localparam int DEF_NWORD   = 4;
  localparam int DEF_PULSE_W = 2;
  localparam int ONEHOT_MAX  = 32;

  // Returns all-zero when idx addresses a word that does not exist.
  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [31:0] idx,
                                                   input int unsigned n);
    onehot = '0;
    if (idx < n && idx < ONEHOT_MAX) onehot[idx[4:0]] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping from NREQ-1 back to 0.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // it unassigned, which would otherwise infer a latch.
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int cand;
      logic [PW-1:0] cand_idx;
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = PW'(cand);
      if (!valid && req[cand_idx]) begin
        valid         = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Arbitrates NREQ requesters onto one bank of D-latch words, sequencing
// data setup, a PULSE_W-cycle enable strobe and a hold cycle per write.
module latch_write_arbiter
  import latch_ctrl_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int DW      = DEF_DW,
  parameter int NWORD   = DEF_NWORD,
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int AW      = (NWORD > 1) ? $clog2(NWORD) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      latch_d,
  output logic [NWORD-1:0]   latch_e,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [DW-1:0]     latch_d_q, latch_d_d;
  logic [NWORD-1:0]  latch_e_q, latch_e_d;
  logic              busy_q, busy_d;
  logic              armed_q, armed_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_valid;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // armed_q holds off arbitration for the first edge after reset release.
  assign armed_d = 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    latch_d_d = latch_d_q;
    latch_e_d = '0;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && arb_valid) begin
          state_d   = ST_SETUP;
          gnt_d     = arb_gnt;
          addr_d    = req_addr[arb_idx*AW +: AW];
          latch_d_d = req_data[arb_idx*DW +: DW];
          busy_d    = 1'b1;
          ptr_d     = (arb_idx == PW'(NREQ-1)) ? '0 : arb_idx + 1'b1;
        end
      end
      ST_SETUP: begin
        state_d   = ST_STROBE;
        latch_e_d = NWORD'(onehot(32'(addr_q), NWORD));
        cnt_d     = CW'(PULSE_W - 1);
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          done_d  = gnt_q;
        end else begin
          cnt_d     = cnt_q - 1'b1;
          latch_e_d = latch_e_q;
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      latch_d_q <= '0;
      latch_e_q <= '0;
      busy_q    <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      latch_d_q <= latch_d_d;
      latch_e_q <= latch_e_d;
      busy_q    <= busy_d;
      armed_q   <= armed_d;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign latch_d = latch_d_q;
  assign latch_e = latch_e_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Self-checking bench for latch_write_arbiter: directed scenarios plus random
// traffic, compared every cycle against a transaction-level reference model.
module tb_latch_write_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int NWORD   = 4;
  localparam int PULSE_W = 2;
  localparam int AW      = 3;  // one spare bit so out-of-range words are reachable

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      latch_d;
  logic [NWORD-1:0]   latch_e;
  logic               busy;

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";

  always #5 clk = ~clk;

  latch_write_arbiter #(
    .NREQ(NREQ), .DW(DW), .NWORD(NWORD), .PULSE_W(PULSE_W), .AW(AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .latch_d  (latch_d),
    .latch_e  (latch_e),
    .busy     (busy)
  );

  // Reference model: one transaction record plus the number of edges since
  // its capture; outputs are derived from that count by the latency rules.
  bit          m_active;
  bit          m_armed;
  int          m_n;
  int          m_ptr;
  int          m_win;
  int          m_addr;
  logic [DW-1:0] m_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_armed  = 1'b0;
    m_n      = 0;
    m_ptr    = 0;
    m_win    = 0;
    m_addr   = 0;
    m_data   = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_active) begin
        m_n++;
        if (m_n == PULSE_W + 2) m_active = 1'b0;
      end else if (m_armed && req != '0) begin
        bit found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          int i = (m_ptr + k) % NREQ;
          if (!found && req[i]) begin
            found = 1'b1;
            m_win = i;
          end
        end
        m_addr   = int'(req_addr[m_win*AW +: AW]);
        m_data   = req_data[m_win*DW +: DW];
        m_ptr    = (m_win + 1) % NREQ;
        m_active = 1'b1;
        m_n      = 0;
      end
      m_armed = 1'b1;
    end
  endtask

  task automatic compare_all();
    logic [31:0] exp_gnt, exp_e, exp_done;
    exp_gnt  = m_active ? (32'd1 << m_win) : 32'd0;
    exp_e    = (m_active && m_n >= 1 && m_n <= PULSE_W && m_addr < NWORD) ? (32'd1 << m_addr) : 32'd0;
    exp_done = (m_active && m_n == PULSE_W + 1) ? (32'd1 << m_win) : 32'd0;
    check("gnt",     32'(gnt),     exp_gnt);
    check("latch_e", 32'(latch_e), exp_e);
    check("done",    32'(done),    exp_done);
    check("latch_d", 32'(latch_d), 32'(m_data));
    check("busy",    32'(busy),    32'(m_active));
    check("e_onehot", 32'($countones(latch_e) <= 1), 32'd1);
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  // Called just after a falling edge; returns at a falling edge with rst_n high.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    run(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    model_reset();
    phase = "reset";
    #2 compare_all();
    @(negedge clk);
    run(2);
    rst_n = 1'b1;
    run(1);

    phase = "single";
    set_req(1, 3'd2, 8'hA5);
    req = 4'b0010;
    cycle();
    req = '0;
    set_req(1, 3'd3, 8'h3C);
    run(6);

    phase = "badaddr";
    set_req(0, 3'd5, 8'h5A);
    req = 4'b0001;
    cycle();
    req = '0;
    run(6);

    phase = "fair";
    do_reset();
    run(1);
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), DW'(8'h10 + i));
    req = 4'b1111;
    run(24);
    req = '0;
    run(6);

    phase = "wrap";
    do_reset();
    run(1);
    req = 4'b0100;
    cycle();
    req = '0;
    run(5);
    req = 4'b1001;
    run(12);
    req = '0;
    run(6);

    phase = "midreset";
    set_req(0, 3'd1, 8'h77);
    req = 4'b0001;
    cycle();
    req = '0;
    run(2);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    run(2);
    req = 4'b0001;
    set_req(0, 3'd3, 8'hC3);
    rst_n = 1'b1;
    cycle();
    cycle();
    req = '0;
    run(6);

    phase = "random";
    for (int c = 0; c < 400; c++) begin
      req = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < NREQ; i++) set_req(i, AW'($urandom), DW'($urandom));
      cycle();
    end
    req = '0;
    run(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
